// File: rtl/pipe_ctrl_pkg.sv
// Shared types and encodings for the RV32 pipeline controller.
// Control bundle layout, field encodings, the NOP bundle and the trap FSM states.
package pipe_ctrl_pkg;

  localparam logic [4:0] ALU_ADD    = 5'd0;
  localparam logic [4:0] ALU_SUB    = 5'd1;
  localparam logic [4:0] ALU_SLL    = 5'd2;
  localparam logic [4:0] ALU_SLT    = 5'd3;
  localparam logic [4:0] ALU_SLTU   = 5'd4;
  localparam logic [4:0] ALU_XOR    = 5'd5;
  localparam logic [4:0] ALU_SRL    = 5'd6;
  localparam logic [4:0] ALU_SRA    = 5'd7;
  localparam logic [4:0] ALU_OR     = 5'd8;
  localparam logic [4:0] ALU_AND    = 5'd9;
  localparam logic [4:0] ALU_PASSB  = 5'd10;
  localparam logic [4:0] ALU_MUL    = 5'd11;
  localparam logic [4:0] ALU_MULH   = 5'd12;
  localparam logic [4:0] ALU_MULHSU = 5'd13;
  localparam logic [4:0] ALU_MULHU  = 5'd14;
  localparam logic [4:0] ALU_DIV    = 5'd15;
  localparam logic [4:0] ALU_DIVU   = 5'd16;
  localparam logic [4:0] ALU_REM    = 5'd17;
  localparam logic [4:0] ALU_REMU   = 5'd18;

  localparam logic [2:0] BR_EQ   = 3'd0;
  localparam logic [2:0] BR_NE   = 3'd1;
  localparam logic [2:0] BR_LT   = 3'd2;
  localparam logic [2:0] BR_GE   = 3'd3;
  localparam logic [2:0] BR_LTU  = 3'd4;
  localparam logic [2:0] BR_GEU  = 3'd5;
  localparam logic [2:0] BR_NONE = 3'd6;
  localparam logic [2:0] BR_JUMP = 3'd7;

  localparam logic [2:0] MEM_B  = 3'd0;
  localparam logic [2:0] MEM_H  = 3'd1;
  localparam logic [2:0] MEM_W  = 3'd2;
  localparam logic [2:0] MEM_BU = 3'd3;
  localparam logic [2:0] MEM_HU = 3'd4;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_CSR = 2'd3;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_J = 3'd1;
  localparam logic [2:0] IMM_U = 3'd2;
  localparam logic [2:0] IMM_B = 3'd3;
  localparam logic [2:0] IMM_S = 3'd4;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  localparam logic [11:0] SYS_MRET = 12'h302;

  // sel_opr_a: 0 = rs1, 1 = pc.  sel_opr_b: 0 = rs2, 1 = immediate.
  typedef struct packed {
    logic       rf_en;
    logic       rd_en;
    logic       wr_en;
    logic       sel_opr_a;
    logic       sel_opr_b;
    logic [4:0] aluop;
    logic [2:0] br_type;
    logic [2:0] mem_type;
    logic [1:0] sel_wb;
    logic [2:0] imm_type;
    logic       csr_rd;
    logic       csr_wr;
    logic       is_mret;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{
    rf_en: 1'b0, rd_en: 1'b0, wr_en: 1'b0, sel_opr_a: 1'b0, sel_opr_b: 1'b0,
    aluop: ALU_ADD, br_type: BR_NONE, mem_type: MEM_B, sel_wb: WB_ALU,
    imm_type: IMM_I, csr_rd: 1'b0, csr_wr: 1'b0, is_mret: 1'b0
  };

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_TRAP = 2'd1,
    ST_MRET = 2'd2
  } state_t;

  // Base-ISA ALU operation selected by funct3 alone (no SUB/SRA).
  function automatic logic [4:0] alu_base(input logic [2:0] funct3);
    case (funct3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/pipe_ctrl_inst_decoder.sv
// Combinational RV32 instruction decoder: control bundle, illegal flag and source usage.
// Illegal encodings collapse to the NOP bundle with no source reads.
module inst_decoder
  import pipe_ctrl_pkg::*;
#(
  parameter int EN_M   = 0,
  parameter int EN_CSR = 1
) (
  input  logic [31:0] inst,
  output ctrl_t       ctrl,
  output logic        illegal,
  output logic        uses_rs1,
  output logic        uses_rs2
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_fields;

  assign opcode        = inst[6:0];
  assign funct3        = inst[14:12];
  assign funct7        = inst[31:25];
  assign unused_fields = ^{inst[19:15], inst[11:7]};

  ctrl_t c;
  logic  ill;
  logic  u1;
  logic  u2;

  always_comb begin
    c   = CTRL_NOP;
    ill = 1'b0;
    u1  = 1'b0;
    u2  = 1'b0;
    case (opcode)
      OP_LUI: begin
        c.rf_en = 1'b1; c.sel_opr_b = 1'b1; c.aluop = ALU_PASSB; c.imm_type = IMM_U;
      end
      OP_AUIPC: begin
        c.rf_en = 1'b1; c.sel_opr_a = 1'b1; c.sel_opr_b = 1'b1; c.imm_type = IMM_U;
      end
      OP_JAL: begin
        c.rf_en = 1'b1; c.sel_opr_a = 1'b1; c.sel_opr_b = 1'b1;
        c.br_type = BR_JUMP; c.sel_wb = WB_PC4; c.imm_type = IMM_J;
      end
      OP_JALR: begin
        c.rf_en = 1'b1; c.sel_opr_b = 1'b1;
        c.br_type = BR_JUMP; c.sel_wb = WB_PC4; c.imm_type = IMM_I;
        u1  = 1'b1;
        ill = (funct3 != 3'b000);
      end
      OP_BRANCH: begin
        c.aluop = ALU_SUB; c.imm_type = IMM_B;
        u1 = 1'b1; u2 = 1'b1;
        case (funct3)
          3'b000:  c.br_type = BR_EQ;
          3'b001:  c.br_type = BR_NE;
          3'b100:  c.br_type = BR_LT;
          3'b101:  c.br_type = BR_GE;
          3'b110:  c.br_type = BR_LTU;
          3'b111:  c.br_type = BR_GEU;
          default: ill = 1'b1;
        endcase
      end
      OP_LOAD: begin
        c.rf_en = 1'b1; c.rd_en = 1'b1; c.sel_opr_b = 1'b1;
        c.sel_wb = WB_MEM; c.imm_type = IMM_I;
        u1 = 1'b1;
        case (funct3)
          3'b000:  c.mem_type = MEM_B;
          3'b001:  c.mem_type = MEM_H;
          3'b010:  c.mem_type = MEM_W;
          3'b100:  c.mem_type = MEM_BU;
          3'b101:  c.mem_type = MEM_HU;
          default: ill = 1'b1;
        endcase
      end
      OP_STORE: begin
        c.wr_en = 1'b1; c.sel_opr_b = 1'b1; c.imm_type = IMM_S;
        u1 = 1'b1; u2 = 1'b1;
        case (funct3)
          3'b000:  c.mem_type = MEM_B;
          3'b001:  c.mem_type = MEM_H;
          3'b010:  c.mem_type = MEM_W;
          default: ill = 1'b1;
        endcase
      end
      OP_IMM: begin
        c.rf_en = 1'b1; c.sel_opr_b = 1'b1; c.imm_type = IMM_I;
        u1 = 1'b1;
        c.aluop = alu_base(funct3);
        if (funct3 == 3'b001) begin
          ill = (funct7 != F7_BASE);
        end else if (funct3 == 3'b101) begin
          if (funct7 == F7_ALT)       c.aluop = ALU_SRA;
          else if (funct7 != F7_BASE) ill = 1'b1;
        end
      end
      OP_REG: begin
        c.rf_en = 1'b1;
        u1 = 1'b1; u2 = 1'b1;
        case (funct7)
          F7_BASE: c.aluop = alu_base(funct3);
          F7_ALT: begin
            if (funct3 == 3'b000)      c.aluop = ALU_SUB;
            else if (funct3 == 3'b101) c.aluop = ALU_SRA;
            else                       ill = 1'b1;
          end
          F7_MUL: begin
            if (EN_M != 0) c.aluop = ALU_MUL + {2'b00, funct3};
            else           ill = 1'b1;
          end
          default: ill = 1'b1;
        endcase
      end
      OP_SYSTEM: begin
        if (EN_CSR == 0) begin
          ill = 1'b1;
        end else if (funct3 == 3'b001) begin
          c.rf_en = 1'b1; c.csr_rd = 1'b1; c.csr_wr = 1'b1;
          c.sel_wb = WB_CSR; c.aluop = ALU_PASSB;
          u1 = 1'b1;
        end else if (funct3 == 3'b000 && inst[31:20] == SYS_MRET) begin
          c.is_mret = 1'b1;
        end else begin
          ill = 1'b1;
        end
      end
      default: ill = 1'b1;
    endcase

    if (ill) begin
      c  = CTRL_NOP;
      u1 = 1'b0;
      u2 = 1'b0;
    end
  end

  assign ctrl     = c;
  assign illegal  = ill;
  assign uses_rs1 = u1;
  assign uses_rs2 = u2;

endmodule

// File: rtl/pipe_ctrl.sv
// RV32 pipeline controller: decode, writeback control stages, load-use hazard and trap/mret sequencing.
// state | meaning
// RUN   | normal issue
// TRAP  | one-cycle illegal-instruction redirect (trap_o, ctrl_flush)
// MRET  | one-cycle return to mepc (mret_o, ctrl_flush)
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int WB_DEPTH = 1,
  parameter int EN_M     = 0,
  parameter int EN_CSR   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid,
  input  logic [31:0] inst,
  input  logic        stall_in,
  input  logic        flush_in,
  output ctrl_t       de_ctrl,
  output logic        illegal,
  output ctrl_t       wb_ctrl,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic        load_use_stall,
  output logic        trap_o,
  output logic        mret_o,
  output logic        ctrl_flush
);

  ctrl_t      dec_ctrl;
  logic       dec_illegal;
  logic       uses_rs1;
  logic       uses_rs2;

  inst_decoder #(.EN_M(EN_M), .EN_CSR(EN_CSR)) u_dec (
    .inst     (inst),
    .ctrl     (dec_ctrl),
    .illegal  (dec_illegal),
    .uses_rs1 (uses_rs1),
    .uses_rs2 (uses_rs2)
  );

  ctrl_t      stg_ctrl  [WB_DEPTH];
  logic       stg_valid [WB_DEPTH];
  logic [4:0] stg_rd    [WB_DEPTH];

  state_t     state;
  state_t     state_nxt;

  logic [4:0] rs1;
  logic [4:0] rs2;
  logic       accept;
  logic       mret_go;

  assign rs1     = inst[19:15];
  assign rs2     = inst[24:20];
  assign de_ctrl = inst_valid ? dec_ctrl : CTRL_NOP;
  assign illegal = inst_valid & dec_illegal;

  assign load_use_stall = inst_valid & stg_valid[0] & stg_ctrl[0].rd_en & (stg_rd[0] != 5'd0) &
                          ((uses_rs1 & (rs1 == stg_rd[0])) | (uses_rs2 & (rs2 == stg_rd[0])));

  assign mret_go = inst_valid & de_ctrl.is_mret & ~stall_in & ~flush_in & ~load_use_stall;

  // MRET is consumed by the FSM, so it never occupies a pipeline slot.
  assign accept = inst_valid & ~flush_in & ~load_use_stall & ~illegal &
                  ~de_ctrl.is_mret & (state == ST_RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WB_DEPTH; i++) begin
        stg_ctrl[i]  <= CTRL_NOP;
        stg_valid[i] <= 1'b0;
        stg_rd[i]    <= 5'd0;
      end
    end else if (!stall_in) begin
      if (accept) begin
        stg_ctrl[0]  <= de_ctrl;
        stg_valid[0] <= 1'b1;
        stg_rd[0]    <= inst[11:7];
      end else begin
        stg_ctrl[0]  <= CTRL_NOP;
        stg_valid[0] <= 1'b0;
        stg_rd[0]    <= 5'd0;
      end
      for (int i = 1; i < WB_DEPTH; i++) begin
        stg_ctrl[i]  <= stg_ctrl[i-1];
        stg_valid[i] <= stg_valid[i-1];
        stg_rd[i]    <= stg_rd[i-1];
      end
    end
  end

  assign wb_ctrl  = stg_ctrl[WB_DEPTH-1];
  assign wb_valid = stg_valid[WB_DEPTH-1];
  assign wb_rd    = stg_rd[WB_DEPTH-1];

  always_ff @(posedge clk) begin
    if (rst) state <= ST_RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    trap_o     = 1'b0;
    mret_o     = 1'b0;
    ctrl_flush = 1'b0;
    case (state)
      ST_RUN: begin
        if (illegal && !stall_in && !flush_in) state_nxt = ST_TRAP;
        else if (mret_go)                      state_nxt = ST_MRET;
      end
      ST_TRAP: begin
        trap_o     = 1'b1;
        ctrl_flush = 1'b1;
        state_nxt  = ST_RUN;
      end
      ST_MRET: begin
        mret_o     = 1'b1;
        ctrl_flush = 1'b1;
        state_nxt  = ST_RUN;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

endmodule
